// File: rtl/count_mon_pkg.sv
// Shared types and defaults for the counter wrap monitor.
// Records, transition classes and default widths.
package count_mon_pkg;

  localparam int C_CW    = 3;
  localparam int C_TW    = 16;
  localparam int C_DEPTH = 4;

  typedef struct packed {
    logic            dir;
    logic            first;
    logic [C_TW-1:0] period;
  } wrap_rec_t;

  typedef enum logic [1:0] {
    HOLD,
    UP,
    DOWN,
    JUMP
  } trans_t;

endpackage

// File: rtl/wrap_rec_fifo.sv
// First-word-fall-through record FIFO for the wrap monitor.
// Push into a full FIFO succeeds only when a pop happens on the same edge.
import count_mon_pkg::*;

module wrap_rec_fifo #(
  parameter int DEPTH = C_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  wrap_rec_t                    din,
  input  logic                         pop,
  output wrap_rec_t                    dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   fill
);

  localparam int AW = $clog2(DEPTH);

  wrap_rec_t       r_mem [DEPTH];
  logic [AW:0]     r_wr;
  logic [AW:0]     r_rd;
  logic            w_do_push;
  logic            w_do_pop;

  assign empty = (r_wr == r_rd);
  assign full  = (r_wr[AW] != r_rd[AW]) &&
                 (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign fill  = r_wr - r_rd;

  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Head slot is presented directly; zeros when nothing is queued.
  assign dout = empty ? '0 : r_mem[r_rd[AW-1:0]];

  // Storage array; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr[AW-1:0]] <= din;
    end
  end

  // Read/write pointers with an extra lap bit for full/empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

endmodule

// File: rtl/count_wrap_monitor.sv
// Observes the counter stage, classifies each step and records wraps.
// Wrap period is measured in cycles and queued for the debug consumer.
import count_mon_pkg::*;

module count_wrap_monitor #(
  parameter int CW    = C_CW,
  parameter int TW    = C_TW,
  parameter int DEPTH = C_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CW-1:0]                cnt_in,
  input  logic                         clr,
  output logic                         rec_valid,
  input  logic                         rec_ready,
  output logic                         rec_dir,
  output logic                         rec_first,
  output logic [TW-1:0]                rec_period,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic                         ovf,
  output logic                         jump_err
);

  localparam logic [CW-1:0] C_ONE  = 1;
  localparam logic [CW-1:0] C_MAX  = '1;
  localparam logic [TW-1:0] T_ONE  = 1;
  localparam logic [TW-1:0] T_MAX  = '1;

  logic [CW-1:0] r_smp;
  logic          r_smp_vld;
  logic [CW-1:0] r_prev;
  logic          r_prev_vld;
  logic [TW-1:0] r_timer;
  logic          r_first_pend;
  logic          r_ovf;
  logic          r_jump_err;

  trans_t        w_cls;
  logic          w_wrap_up;
  logic          w_wrap_dn;
  logic          w_wrap;
  logic          w_jump;
  logic [TW-1:0] w_period;
  wrap_rec_t     w_push_rec;
  wrap_rec_t     w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_ovf_set;

  // Two-deep sample pipe: classification compares the last two samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_smp      <= '0;
      r_smp_vld  <= 1'b0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
    end else begin
      r_smp      <= cnt_in;
      r_smp_vld  <= 1'b1;
      r_prev     <= r_smp;
      r_prev_vld <= r_smp_vld;
    end
  end

  // Classify the step; up wins when CW=1 makes up and down identical.
  always_comb begin
    w_cls = HOLD;
    if (r_prev_vld) begin
      priority case (1'b1)
        (r_smp == r_prev):         w_cls = HOLD;
        (r_smp == r_prev + C_ONE): w_cls = UP;
        (r_smp == r_prev - C_ONE): w_cls = DOWN;
        default:                   w_cls = JUMP;
      endcase
    end
  end

  assign w_wrap_up = (w_cls == UP) && (r_prev == C_MAX);
  assign w_wrap_dn = (w_cls == DOWN) && (r_prev == '0);
  assign w_wrap    = w_wrap_up | w_wrap_dn;
  assign w_jump    = (w_cls == JUMP);

  assign w_period = (r_timer == T_MAX) ? T_MAX : r_timer + T_ONE;

  assign w_push_rec.dir    = w_wrap_up;
  assign w_push_rec.first  = r_first_pend;
  assign w_push_rec.period = w_period;

  // Saturating cycle timer, restarted by a wrap or a jump.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_wrap || w_jump) begin
      r_timer <= '0;
    end else if (r_timer != T_MAX) begin
      r_timer <= r_timer + T_ONE;
    end
  end

  // Period is unreliable until a wrap follows reset or a jump.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_first_pend <= 1'b1;
    end else if (w_jump) begin
      r_first_pend <= 1'b1;
    end else if (w_wrap) begin
      r_first_pend <= 1'b0;
    end
  end

  assign w_pop     = rec_valid & rec_ready;
  assign w_ovf_set = w_wrap & w_full & ~w_pop;

  // Sticky error flags; a new event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf      <= 1'b0;
      r_jump_err <= 1'b0;
    end else begin
      r_ovf      <= w_ovf_set | (r_ovf & ~clr);
      r_jump_err <= w_jump | (r_jump_err & ~clr);
    end
  end

  wrap_rec_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_wrap),
    .din   (w_push_rec),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .fill  (fill)
  );

  assign rec_valid  = ~w_empty;
  assign rec_dir    = w_head.dir;
  assign rec_first  = w_head.first;
  assign rec_period = w_head.period;
  assign ovf        = r_ovf;
  assign jump_err   = r_jump_err;

endmodule

// File: doc/count_wrap_monitor.md
# count_wrap_monitor

Downstream observer of the 3-bit counter stage. It samples the counter output every cycle and classifies each transition as hold, up-step, down-step or illegal jump. On every wrap-around it measures the wrap period in clock cycles and pushes a record into a small FIFO. Records are drained over a valid/ready handshake by the status/debug logic.

## Interface
- CW, 3: width of observed count.
- TW, 16: width of period timer/field.
- DEPTH, 4: record FIFO depth (power of two, ≥2).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high; clock clk.
- cnt_in  in  CW  counter value, sampled every rising edge.
- clr  in  1  synchronous clear of sticky flags (ovf, jump_err); FIFO contents untouched.
- rec_valid  out  1  record available.
- rec_ready  in  1  consumer accepts record.
- rec_dir  out  1  wrap direction: 1 = up (MAX→0), 0 = down (0→MAX).
- rec_first  out  1  period not meaningful (first wrap since reset or since a jump).
- rec_period  out  TW  cycles since previous wrap, saturating.
- fill  out  $clog2(DEPTH+1)  current FIFO occupancy.
- ovf  out  1  sticky: a record was dropped because the FIFO was full.
- jump_err  out  1  sticky: illegal transition seen.

## Operation
- prev register holds last cnt_in; prev_vld = 0 after reset, set after first sample. No classification while prev_vld = 0.
- Per cycle (prev_vld = 1), MAX = 2^CW−1, arithmetic mod 2^CW:
  - cnt_in == prev: hold.
  - cnt_in == prev+1: up-step; wrap-up if prev == MAX.
  - cnt_in == prev−1: down-step; wrap-down if prev == 0.
  - otherwise: jump; set jump_err, set first_pend, clear timer, no record.
- Timer: cleared on reset; increments every cycle, saturates at 2^TW−1 (no wrap).
- On wrap cycle: push record {dir, first_pend, min(timer+1, 2^TW−1)}; timer ← 0; first_pend ← 0.
- first_pend = 1 after reset and after any jump.
- FIFO: push on wrap, pop on rec_valid & rec_ready. If full with simultaneous pop: both occur, fill unchanged. If full without pop: record dropped, ovf ← 1.
- clr clears ovf and jump_err; if the same cycle sets a flag, set wins.
- Record outputs hold stable while rec_valid & !rec_ready.

## Timing
- Reset values: rec_valid 0, rec_dir 0, rec_first 0, rec_period 0, fill 0, ovf 0, jump_err 0; prev_vld 0, timer 0, first_pend 1.
- Wrap sampled at edge N → record visible (rec_valid = 1, fill incremented) after edge N+1. One cycle push-to-output latency, first-word fall-through.
- Pop at edge M: the next record (if any) is presented from edge M onward; fill decrements at M.
- jump_err/ovf assert one cycle after the offending sample edge.
- Back-to-back wraps (CW = 1 or period 1) are supported: one push per cycle.
- Reset mid-operation: FIFO flushed, all state to reset values on that edge; rst has priority over clr and push/pop.

## Structure
- Package count_mon_pkg: wrap_rec_t struct {dir, first, period[TW-1:0]}, transition-class enum {HOLD, UP, DOWN, JUMP}, default CW/TW/DEPTH constants.
- Sub-module wrap_rec_fifo: synchronous FIFO of wrap_rec_t, FWFT, parameter DEPTH, with push/pop/full/empty/fill. Classifier, timer and flags live in the top level.

## Test plan
- Reset then up-count 0..7,0..7 with cnt_in stepping every cycle → first record {dir 1, first 1}; second {dir 1, first 0, period 8}; fill 2, ovf 0.
- Down-count stepping every 2 cycles, 7→0→7 repeated → records dir 0, period 16 after the first; jump_err stays 0.
- Inject 3→6 mid-count, then resume → jump_err = 1 one cycle later, no record; next wrap has first 1; clr clears jump_err.
- Hold rec_ready = 0, generate 5 wraps with DEPTH 4 → fill 4, ovf 1 after the fifth; then drain → 4 records in order with stable outputs while stalled.
- Full FIFO with rec_ready = 1 on the same cycle as a wrap → no drop, fill stays 4, ovf 0.
- Hold cnt_in constant for 70000 cycles, then wrap (TW 16) → period 65535 (saturated). Assert rst mid-stream → all outputs 0 on the next cycle, and the next wrap has first 1.
